// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers.
// Multiplies take 5 cycles and divides take 10 cycles. mthi and mtlo write in a
// single cycle. A divide by zero runs the full 10 cycles and leaves HI/LO
// untouched.
// Optional build macro: MDU_MADD_EN enables md_op=7 (madd, HI:LO += signed a*b).
// Without it, md_op=7 is a no-op.
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] mul_res;
    logic [63:0] div_res;

    // 64-bit product. Sign-extending the operands makes the low 64 bits
    // of the product correct for both signed and unsigned multiplies.
    function automatic logic [63:0] mul_result(input logic is_signed,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
        eb = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Divide on magnitudes, then restore the signs: the quotient is truncated
    // toward zero and the remainder follows the dividend. This avoids the
    // overflow case 0x80000000 / -1, which gives quotient 0x80000000 and remainder 0.
    // The result is packed as {remainder, quotient}.
    function automatic logic [63:0] div_result(input logic is_signed,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] ua, ub, uq, ur;
        logic        neg_q, neg_r;
        neg_q = is_signed & (a[31] ^ b[31]);
        neg_r = is_signed & a[31];
        ua = (is_signed & a[31]) ? (32'd0 - a) : a;
        ub = (is_signed & b[31]) ? (32'd0 - b) : b;
        uq = (ub == 32'd0) ? 32'd0 : ua / ub;
        ur = (ub == 32'd0) ? 32'd0 : ua % ub;
        return {(neg_r ? (32'd0 - ur) : ur), (neg_q ? (32'd0 - uq) : uq)};
    endfunction

    // Final results, computed from the operands latched at issue.
    always_comb begin
        mul_res = mul_result(op_q != OP_MULTU, a_q, b_q);
`ifdef MDU_MADD_EN
        if (op_q == OP_MADD) mul_res = mul_res + {hi_q, lo_q};
`endif
        div_res = div_result(op_q == OP_DIV, a_q, b_q);
    end

    // Next-state logic: issue in IDLE, count down, and write back on the final edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            op_d = md_op; a_d = rs_data; b_d = rt_data;
                            cnt_d = 4'd5; state_d = MUL;
                        end
`ifdef MDU_MADD_EN
                        OP_MADD: begin
                            op_d = md_op; a_d = rs_data; b_d = rt_data;
                            cnt_d = 4'd5; state_d = MUL;
                        end
`endif
                        OP_DIV, OP_DIVU: begin
                            op_d = md_op; a_d = rs_data; b_d = rt_data;
                            cnt_d = 4'd10; state_d = DIV;
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    hi_d = mul_res[63:32];
                    lo_d = mul_res[31:0];
                end
            end
            DIV: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    if (b_q != 32'd0) begin
                        hi_d = div_res[63:32];
                        lo_d = div_res[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight and clears HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
